// File: rtl/switches_pio_in.sv
// Avalon-MM input PIO: synchronises and debounces switch inputs and latches edges into sticky bits with a maskable IRQ.
// Read data is registered with one cycle of latency; writes take effect on the sampling edge; there are no wait states.
module switches_pio_in #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int EDGE_TYPE       = 2
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic             avs_chipselect,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] pio_in
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] ecap_q, ecap_d;
    logic [WIDTH-1:0] edge_set;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [31:0]      readdata_q, readdata_d;
    logic             rd_en, wr_en;

    assign rd_en = avs_chipselect & avs_read;
    assign wr_en = avs_chipselect & avs_write;

    // The counter only runs while the synchronised level disagrees with the accepted one.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        case (EDGE_TYPE)
            0:       edge_set = stable_d & ~stable_q;
            1:       edge_set = ~stable_d & stable_q;
            default: edge_set = stable_d ^ stable_q;
        endcase
    end

    // Set is OR-ed in after the clear so a coincident edge keeps the bit.
    always_comb begin
        mask_d = mask_q;
        ecap_d = ecap_q;
        if (wr_en && avs_address == 2'd2) begin
            mask_d = avs_writedata[WIDTH-1:0];
        end
        if (wr_en && avs_address == 2'd3) begin
            ecap_d = ecap_q & ~avs_writedata[WIDTH-1:0];
        end
        ecap_d = ecap_d | edge_set;
    end

    always_comb begin
        readdata_d = readdata_q;
        if (rd_en) begin
            case (avs_address)
                2'd0:    readdata_d = 32'(stable_q);
                2'd2:    readdata_d = 32'(mask_q);
                2'd3:    readdata_d = 32'(ecap_q);
                default: readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            mask_q     <= '0;
            ecap_q     <= '0;
            readdata_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= pio_in;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            mask_q     <= mask_d;
            ecap_q     <= ecap_d;
            readdata_q <= readdata_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign avs_readdata = readdata_q;
    assign irq          = |(ecap_q & mask_q);

endmodule
